// File: rtl/weight_buf_pkg.sv
// Shared types and width helpers for the weight ping-pong buffer.
// Default-parameter widths are exported for users that do not override them.
package weight_buf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STREAM  = 2'd1,
      ST_RELEASE = 2'd2
   } rd_state_t;

   function automatic int calc_pass_w(input int max_passes);
      return $clog2(max_passes + 1);
   endfunction

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int calc_cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_MAX_PASSES = 16;
   localparam int DEF_KSIZE      = 5;
   localparam int PASS_W         = calc_pass_w(DEF_MAX_PASSES);
   localparam int COL_CNT_W      = calc_cnt_w(DEF_KSIZE);

endpackage

// File: rtl/weight_bank.sv
// One KSIZE x KSIZE pixel bank: row-major write port, flush clear and a
// combinational column-select mux (row 0 in the least significant slot).
module weight_bank
   import weight_buf_pkg::*;
#(
   parameter int PIX_WIDTH = 8,
   parameter int KSIZE     = 5
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_flush,
   input  logic                                i_wr_en,
   input  logic [calc_cnt_w(KSIZE*KSIZE)-1:0]  i_wr_addr,
   input  logic [PIX_WIDTH-1:0]                i_wr_data,
   input  logic [calc_cnt_w(KSIZE)-1:0]        i_col_sel,
   output logic [PIX_WIDTH*KSIZE-1:0]          o_col_data
);

   localparam int N_PIX  = KSIZE * KSIZE;
   localparam int ADDR_W = calc_cnt_w(N_PIX);

   logic [PIX_WIDTH-1:0] mem [N_PIX];

   // NOTE: the bank is a small register file, so it is reset and flushed
   // explicitly; a RAM macro could not offer the zero-contents guarantee.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < N_PIX; i++) mem[i] <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < N_PIX; i++) mem[i] <= '0;
      end else if (i_wr_en) begin
         mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_comb begin
      o_col_data = '0;
      for (int r = 0; r < KSIZE; r++) begin
         o_col_data[r*PIX_WIDTH +: PIX_WIDTH] =
            mem[ADDR_W'(r * KSIZE) + ADDR_W'(i_col_sel)];
      end
   end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Two-bank weight buffer: one bank loads pixels while the other replays its
// kernel column by column for the requested number of passes.
module weight_pingpong_buffer
   import weight_buf_pkg::*;
#(
   parameter int PIX_WIDTH  = 8,
   parameter int KSIZE      = 5,
   parameter int MAX_PASSES = 16
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic                                  i_flush,
   input  logic                                  i_wr_valid,
   output logic                                  o_wr_ready,
   input  logic [PIX_WIDTH-1:0]                  i_wr_data,
   input  logic [calc_pass_w(MAX_PASSES)-1:0]    i_num_passes,
   output logic                                  o_col_valid,
   input  logic                                  i_col_ready,
   output logic [PIX_WIDTH*KSIZE-1:0]            o_col_data,
   output logic                                  o_col_last,
   output logic                                  o_chan_done,
   output logic [1:0]                            o_bank_full,
   output logic                                  o_busy
);

   localparam int N_PIX    = KSIZE * KSIZE;
   localparam int P_W      = calc_pass_w(MAX_PASSES);
   localparam int ADDR_W   = calc_cnt_w(N_PIX);
   localparam int COL_W    = calc_cnt_w(KSIZE);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_PIX - 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(KSIZE - 1);
   localparam logic [P_W-1:0]    PASS_MAX  = P_W'(MAX_PASSES);

   logic                         wr_bank, rd_bank;
   logic [ADDR_W-1:0]            wr_ptr;
   logic [1:0]                   bank_full, bank_full_d;
   logic [P_W-1:0]               passes_q [2];
   rd_state_t                    state;
   logic [COL_W-1:0]             col_cnt;
   logic [P_W-1:0]               pass_cnt;
   logic                         issued_all;
   logic [PIX_WIDTH*KSIZE-1:0]   bank_cols [2];
   logic                         wr_fire, wr_last;

   function automatic logic [P_W-1:0] sat_passes(input logic [P_W-1:0] n);
      if (n == '0)      return P_W'(1);
      if (n > PASS_MAX) return PASS_MAX;
      return n;
   endfunction

   assign o_wr_ready  = ~bank_full[wr_bank];
   assign wr_fire     = i_wr_valid & o_wr_ready & ~i_flush;
   assign wr_last     = wr_fire & (wr_ptr == ADDR_LAST);
   assign o_bank_full = bank_full;
   assign o_busy      = (state != ST_IDLE);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      weight_bank #(.PIX_WIDTH(PIX_WIDTH), .KSIZE(KSIZE)) u_bank (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_flush    (i_flush),
         .i_wr_en    (wr_fire & (wr_bank == 1'(b))),
         .i_wr_addr  (wr_ptr),
         .i_wr_data  (i_wr_data),
         .i_col_sel  (col_cnt),
         .o_col_data (bank_cols[b])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n || i_flush) begin
         wr_bank     <= 1'b0;
         wr_ptr      <= '0;
         passes_q[0] <= '0;
         passes_q[1] <= '0;
      end else if (wr_fire) begin
         if (wr_last) begin
            wr_ptr            <= '0;
            wr_bank           <= ~wr_bank;
            passes_q[wr_bank] <= sat_passes(i_num_passes);
         end else begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
      end
   end

   // A release and a completed load never target the same bank, so both
   // updates can be applied in one cycle.
   always_comb begin
      bank_full_d = bank_full;
      if (state == ST_RELEASE) bank_full_d[rd_bank] = 1'b0;
      if (wr_last)             bank_full_d[wr_bank] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     bank_full <= 2'b00;
      else if (i_flush) bank_full <= 2'b00;
      else              bank_full <= bank_full_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n || i_flush) begin
         state       <= ST_IDLE;
         rd_bank     <= 1'b0;
         col_cnt     <= '0;
         pass_cnt    <= '0;
         issued_all  <= 1'b0;
         o_col_valid <= 1'b0;
         o_col_data  <= '0;
         o_col_last  <= 1'b0;
         o_chan_done <= 1'b0;
      end else begin
         o_chan_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bank_full[rd_bank]) begin
                  state      <= ST_STREAM;
                  col_cnt    <= '0;
                  pass_cnt   <= '0;
                  issued_all <= 1'b0;
               end
            end
            ST_STREAM: begin
               // Output register refills whenever it is empty or being drained.
               if (!o_col_valid || i_col_ready) begin
                  if (o_col_valid && issued_all) begin
                     o_col_valid <= 1'b0;
                     o_col_last  <= 1'b0;
                     state       <= ST_RELEASE;
                  end else begin
                     o_col_valid <= 1'b1;
                     o_col_data  <= bank_cols[rd_bank];
                     o_col_last  <= (col_cnt == COL_LAST);
                     if (col_cnt == COL_LAST) begin
                        col_cnt <= '0;
                        if ((pass_cnt + P_W'(1)) == passes_q[rd_bank]) issued_all <= 1'b1;
                        else pass_cnt <= pass_cnt + P_W'(1);
                     end else begin
                        col_cnt <= col_cnt + COL_W'(1);
                     end
                  end
               end
            end
            ST_RELEASE: begin
               state       <= ST_IDLE;
               rd_bank     <= ~rd_bank;
               o_chan_done <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
